// File: rtl/hough_line_dispatcher_if.sv
// Purpose : accumulator read port plus line-draw request/finish handshake
//           between the Hough line dispatcher and its neighbours.
// Signals : accum_rd_addr      - accumulator word address (angle*RHO_BINS + rho)
//           accum_rd_data      - accumulator word, valid one cycle after address
//           start_draw_a_line  - one-cycle draw request to the highlighter
//           angle, radius      - bin coordinates of the current request
//           finish_draw_a_line - highlighter status, high = idle/finished
// Modports: master = dispatcher side, slave = RAM/highlighter side.
interface hough_line_dispatcher_if #(
   parameter int unsigned ANGLE_RANGE = 180,
   parameter int unsigned RHO_BINS    = 1024,
   parameter int unsigned ACC_WIDTH   = 16,
   parameter int unsigned IMAGE_SIZE  = 388800
);
   localparam int unsigned ADDR_W = $clog2(ANGLE_RANGE * RHO_BINS);
   localparam int unsigned ANG_W  = $clog2(ANGLE_RANGE);
   localparam int unsigned RAD_W  = $clog2(IMAGE_SIZE);

   logic [ADDR_W-1:0]    accum_rd_addr;
   logic [ACC_WIDTH-1:0] accum_rd_data;
   logic                 start_draw_a_line;
   logic [ANG_W-1:0]     angle;
   logic [RAD_W-1:0]     radius;
   logic                 finish_draw_a_line;

   modport master (
      output accum_rd_addr, start_draw_a_line, angle, radius,
      input  accum_rd_data, finish_draw_a_line
   );

   modport slave (
      input  accum_rd_addr, start_draw_a_line, angle, radius,
      output accum_rd_data, finish_draw_a_line
   );
endinterface

// File: rtl/hough_line_dispatcher.sv
// Purpose : scans the Hough accumulator after voting and issues one line-draw
//           request per bin whose vote count reaches THRESHOLD, waiting for the
//           highlighter to finish each line before resuming the scan.
// Ports   : clock, reset (synchronous, active-high)
//           start       - one-cycle pulse, begins a scan when idle
//           bus         - hough_line_dispatcher_if.master (RAM read + draw handshake)
//           busy        - high from scan start until done
//           done        - one-cycle pulse at scan end
//           lines_found - saturating count of requests in current/last scan
// Config  : define HOUGH_MAX_LINES_EN to end the scan once MAX_LINES requests
//           have been drawn; otherwise the whole accumulator is always scanned.
module hough_line_dispatcher #(
   parameter int unsigned ANGLE_RANGE = 180,
   parameter int unsigned RHO_BINS    = 1024,
   parameter int unsigned ACC_WIDTH   = 16,
   parameter int unsigned IMAGE_SIZE  = 388800,
   parameter int unsigned THRESHOLD   = 100,
   parameter int unsigned MAX_LINES   = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   hough_line_dispatcher_if.master bus,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             lines_found
);
   localparam int unsigned ADDR_W = $clog2(ANGLE_RANGE * RHO_BINS);
   localparam int unsigned ANG_W  = $clog2(ANGLE_RANGE);
   localparam int unsigned RHO_W  = $clog2(RHO_BINS);
   localparam int unsigned RAD_W  = $clog2(IMAGE_SIZE);
   localparam int unsigned ACC_CMP_W = 32;

   localparam logic [ANG_W-1:0] ANG_LAST = ANG_W'(ANGLE_RANGE - 1);
   localparam logic [RHO_W-1:0] RHO_LAST = RHO_W'(RHO_BINS - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_READ, ST_CHECK, ST_REQ, ST_ACK, ST_DRAW, ST_DONE
   } state_t;

   state_t             state_q,      state_d;
   logic [ANG_W-1:0]   ang_cnt_q,    ang_cnt_d;
   logic [RHO_W-1:0]   rho_cnt_q,    rho_cnt_d;
   logic [ADDR_W-1:0]  addr_q,       addr_d;
   logic [ANG_W-1:0]   angle_q,      angle_d;
   logic [RAD_W-1:0]   radius_q,     radius_d;
   logic               start_draw_q, start_draw_d;
   logic               busy_q,       busy_d;
   logic               done_q,       done_d;
   logic [15:0]        lines_q,      lines_d;

   logic last_bin;
   logic leave_bin;
   logic cap_hit;

   assign last_bin = (ang_cnt_q == ANG_LAST) && (rho_cnt_q == RHO_LAST);

`ifdef HOUGH_MAX_LINES_EN
   assign cap_hit = (lines_q >= 16'(MAX_LINES));
`else
   wire unused_max_lines = |32'(MAX_LINES);
   assign cap_hit = 1'b0;
`endif

   // State register and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ang_cnt_q    <= '0;
         rho_cnt_q    <= '0;
         addr_q       <= '0;
         angle_q      <= '0;
         radius_q     <= '0;
         start_draw_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         lines_q      <= '0;
      end else begin
         state_q      <= state_d;
         ang_cnt_q    <= ang_cnt_d;
         rho_cnt_q    <= rho_cnt_d;
         addr_q       <= addr_d;
         angle_q      <= angle_d;
         radius_q     <= radius_d;
         start_draw_q <= start_draw_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         lines_q      <= lines_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      ang_cnt_d    = ang_cnt_q;
      rho_cnt_d    = rho_cnt_q;
      addr_d       = addr_q;
      angle_d      = angle_q;
      radius_d     = radius_q;
      start_draw_d = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      lines_d      = lines_q;
      leave_bin    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               ang_cnt_d = '0;
               rho_cnt_d = '0;
               addr_d    = '0;
               lines_d   = '0;
               busy_d    = 1'b1;
               state_d   = ST_READ;
            end
         end
         ST_READ:  state_d = ST_CHECK;
         ST_CHECK: begin
            if (ACC_CMP_W'(bus.accum_rd_data) >= THRESHOLD) begin
               angle_d      = ang_cnt_q;
               radius_d     = RAD_W'(rho_cnt_q);
               start_draw_d = 1'b1;
               state_d      = ST_REQ;
            end else begin
               leave_bin = 1'b1;
            end
         end
         ST_REQ: begin
            if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (!bus.finish_draw_a_line) state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (bus.finish_draw_a_line) begin
               leave_bin = 1'b1;
               if (cap_hit) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Move past the current bin: finish on the last one, else step rho/angle.
      if (leave_bin && !done_d) begin
         if (last_bin) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end else begin
            state_d = ST_READ;
            addr_d  = addr_q + ADDR_W'(1);
            if (rho_cnt_q == RHO_LAST) begin
               rho_cnt_d = '0;
               ang_cnt_d = ang_cnt_q + ANG_W'(1);
            end else begin
               rho_cnt_d = rho_cnt_q + RHO_W'(1);
            end
         end
      end
   end

   assign bus.accum_rd_addr     = addr_q;
   assign bus.start_draw_a_line = start_draw_q;
   assign bus.angle             = angle_q;
   assign bus.radius            = radius_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign lines_found           = lines_q;
endmodule

// File: tb/tb_hough_line_dispatcher.sv
// Directed bench for hough_line_dispatcher on a 4x8 accumulator, with a
// registered RAM model, a highlighter model with programmable hold time and a
// per-cycle monitor comparing requests against an expected dispatch list.
module tb_hough_line_dispatcher;
   localparam int unsigned AR   = 4;
   localparam int unsigned RB   = 8;
   localparam int unsigned N    = AR * RB;
   localparam int unsigned TH   = 5;
   localparam int unsigned MAXL = 2;
`ifdef HOUGH_MAX_LINES_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] lines_found;

   always #5 clock = ~clock;

   hough_line_dispatcher_if #(.ANGLE_RANGE(AR), .RHO_BINS(RB), .ACC_WIDTH(16),
                              .IMAGE_SIZE(388800)) bus ();

   hough_line_dispatcher #(.ANGLE_RANGE(AR), .RHO_BINS(RB), .ACC_WIDTH(16),
                           .IMAGE_SIZE(388800), .THRESHOLD(TH), .MAX_LINES(MAXL)) dut (
      .clock(clock), .reset(reset), .start(start), .bus(bus),
      .busy(busy), .done(done), .lines_found(lines_found)
   );

   // Accumulator RAM: data one cycle after the address.
   logic [15:0] mem [N];
   always @(posedge clock) bus.accum_rd_data <= mem[bus.accum_rd_addr];

   // Highlighter: finish low for hold_len cycles after each request.
   int hold_len = 1;
   int hl_cnt;
   always @(posedge clock) begin
      if (reset) begin
         bus.finish_draw_a_line <= 1'b1;
         hl_cnt <= 0;
      end else if (bus.start_draw_a_line) begin
         bus.finish_draw_a_line <= 1'b0;
         hl_cnt <= hold_len - 1;
      end else if (hl_cnt != 0) begin
         hl_cnt <= hl_cnt - 1;
      end else begin
         bus.finish_draw_a_line <= 1'b1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected dispatch list and scan length, written by the stimulus.
   int exp_a [64];
   int exp_r [64];
   int exp_n;
   int exp_t;
   int scan_id = 0;
   bit mon_en  = 1'b0;
   int last_cycles;

   task automatic build_model(input int hold);
      int cnt = 0;
      int scanned = N;
      for (int i = 0; i < N; i++) begin
         if (int'(mem[i]) >= TH) begin
            exp_a[cnt] = i / RB;
            exp_r[cnt] = i % RB;
            cnt++;
            if (CAP_EN && cnt == MAXL) begin
               scanned = i + 1;
               break;
            end
         end
      end
      exp_n = cnt;
      // each bin reads+checks in 2 cycles; a peak adds REQ, 1 ACK and hold DRAW cycles
      exp_t = 2 * scanned + cnt * (2 + hold);
   endtask

   // Per-cycle monitor.
   int seen_id = -1;
   int idx;
   int last_a, last_r;
   bit have_req;
   bit prev_sd = 1'b0;
   int got_a [64];
   int got_r [64];
   int n_got = 0;

   always @(negedge clock) begin
      if (seen_id != scan_id) begin
         seen_id  = scan_id;
         idx      = 0;
         have_req = 1'b0;
         n_got    = 0;
      end
      if (mon_en) begin
         if (bus.start_draw_a_line) begin
            chk("req_single_cycle", longint'(prev_sd), 0);
            if (idx < exp_n) begin
               chk("req_angle",  longint'(bus.angle),  exp_a[idx]);
               chk("req_radius", longint'(bus.radius), exp_r[idx]);
               last_a = exp_a[idx];
               last_r = exp_r[idx];
            end else begin
               chk("req_extra", idx + 1, exp_n);
               last_a = int'(bus.angle);
               last_r = int'(bus.radius);
            end
            if (n_got < 64) begin
               got_a[n_got] = int'(bus.angle);
               got_r[n_got] = int'(bus.radius);
            end
            n_got++;
            idx++;
            have_req = 1'b1;
         end else if (have_req) begin
            chk("hold_angle",  longint'(bus.angle),  last_a);
            chk("hold_radius", longint'(bus.radius), last_r);
         end
         if (have_req && !bus.finish_draw_a_line)
            chk("addr_hold_while_drawing", longint'(bus.accum_rd_addr), last_a * RB + last_r);
      end
      prev_sd = bus.start_draw_a_line;
   end

   task automatic run_scan(input int hold, input bit extra);
      int k;
      hold_len = hold;
      build_model(hold);
      scan_id++;
      mon_en = 1'b1;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_rise", longint'(busy), 1);
      chk("first_addr", longint'(bus.accum_rd_addr), 0);
      k = 0;
      while (done !== 1'b1 && k < 4000) begin
         @(negedge clock);
         k++;
         start = extra && (k == 5 || k == 45);
      end
      start = 1'b0;
      last_cycles = k;
      chk("scan_cycles", k, exp_t);
      chk("busy_at_done", longint'(busy), 0);
      chk("lines_found", longint'(lines_found), exp_n);
      chk("request_count", n_got, exp_n);
      @(negedge clock);
      chk("done_one_cycle", longint'(done), 0);
      chk("idle_not_busy", longint'(busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  longint'(busy), 0);
      chk({tag, "_done"},  longint'(done), 0);
      chk({tag, "_req"},   longint'(bus.start_draw_a_line), 0);
      chk({tag, "_angle"}, longint'(bus.angle), 0);
      chk({tag, "_radius"},longint'(bus.radius), 0);
      chk({tag, "_addr"},  longint'(bus.accum_rd_addr), 0);
      chk({tag, "_lines"}, longint'(lines_found), 0);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < N; i++) mem[i] = 16'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check_all_zero("reset");

      // All bins empty: no requests, done 64 cycles after busy.
      run_scan(1, 1'b0);
      chk("empty_cycles_lit", last_cycles, 64);
      chk("empty_lines_lit", longint'(lines_found), 0);

      // Peaks at (2,3)=threshold and last bin (3,7); (2,2)=threshold-1 is not a peak.
      mem[18] = 16'd4;
      mem[19] = 16'd5;
      mem[31] = 16'd9;
      run_scan(1, 1'b0);
      chk("peak_cycles_lit", last_cycles, 70);
      chk("peak_lines_lit", longint'(lines_found), 2);
      chk("peak0_angle_lit", got_a[0], 2);
      chk("peak0_radius_lit", got_r[0], 3);
      chk("peak1_angle_lit", got_a[1], 3);
      chk("peak1_radius_lit", got_r[1], 7);

      // Slow highlighter: finish held low for 10 cycles per line.
      run_scan(10, 1'b0);
      chk("slow_cycles_lit", last_cycles, 88);

      // Start pulses while busy (mid-scan and mid-draw) are ignored.
      run_scan(10, 1'b1);
      chk("restart_ignored_cycles_lit", last_cycles, 88);
      chk("restart_ignored_lines_lit", longint'(lines_found), 2);

      // Reset during the DRAW of (1,4).
      for (int i = 0; i < N; i++) mem[i] = 16'd0;
      mem[12] = 16'd9;
      hold_len = 10;
      build_model(10);
      scan_id++;
      mon_en = 1'b1;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      while (bus.start_draw_a_line !== 1'b1 && k < 500) begin
         @(negedge clock);
         k++;
      end
      chk("rst_req_seen", longint'(bus.start_draw_a_line), 1);
      chk("rst_req_angle_lit", longint'(bus.angle), 1);
      chk("rst_req_radius_lit", longint'(bus.radius), 4);
      repeat (4) @(negedge clock);
      chk("rst_in_draw", longint'(bus.finish_draw_a_line), 0);
      mon_en = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_all_zero("midreset");
      @(negedge clock);
      chk("midreset_no_req", longint'(bus.start_draw_a_line), 0);
      chk("midreset_idle", longint'(busy), 0);
      run_scan(1, 1'b0);
      chk("rescan_cycles_lit", last_cycles, 67);
      chk("rescan_angle_lit", got_a[0], 1);
      chk("rescan_radius_lit", got_r[0], 4);

`ifdef HOUGH_MAX_LINES_EN
      // Cap of 2 lines with every bin a peak.
      for (int i = 0; i < N; i++) mem[i] = 16'd9;
      run_scan(1, 1'b0);
      chk("cap_cycles_lit", last_cycles, 10);
      chk("cap_lines_lit", longint'(lines_found), 2);
      chk("cap0_angle_lit", got_a[0], 0);
      chk("cap0_radius_lit", got_r[0], 0);
      chk("cap1_angle_lit", got_a[1], 0);
      chk("cap1_radius_lit", got_r[1], 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hough_line_dispatcher.md
# hough_line_dispatcher

Scans the Hough accumulator memory after voting completes and issues one line-draw request per bin whose vote count meets a threshold. It is the initiator side of the line-draw handshake: it drives angle/radius and `start_draw_a_line` into the line highlighter, then waits for that block's `finish_draw_a_line` before resuming the scan. It sits between the accumulator RAM (read port) and the highlighter that writes the overlay image.

## Interface
- `ANGLE_RANGE`, 180, number of angle bins (1° steps).
- `RHO_BINS`, 1024, number of radius bins per angle.
- `ACC_WIDTH`, 16, accumulator word width, unsigned.
- `IMAGE_SIZE`, 388800, sets radius port width.
- `THRESHOLD`, 100, minimum vote count for a dispatch.
- `MAX_LINES`, 16, dispatch cap, used only when `HOUGH_MAX_LINES_EN` is defined.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a scan when idle.
- `accum_rd_addr`  out  $clog2(ANGLE_RANGE*RHO_BINS)  accumulator read address = angle*RHO_BINS + rho.
- `accum_rd_data`  in  ACC_WIDTH  read data, valid exactly 1 cycle after the address.
- `start_draw_a_line`  out  1  one-cycle request pulse to the highlighter.
- `angle`  out  $clog2(ANGLE_RANGE)  angle bin of current request.
- `radius`  out  $clog2(IMAGE_SIZE)  rho bin of current request, zero-extended.
- `finish_draw_a_line`  in  1  highlighter status; high = idle/finished.
- `busy`  out  1  high from scan start until done.
- `done`  out  1  one-cycle pulse at scan end.
- `lines_found`  out  16  dispatches in current/last scan.

## Operation
- States: IDLE, READ, CHECK, REQ, ACK, DRAW, DONE.
- IDLE: `start`=1 clears angle/rho counters and `lines_found` -> READ. `start` in any other state is ignored.
- READ: drive `accum_rd_addr` from counters -> CHECK.
- CHECK: if `accum_rd_data >= THRESHOLD`, latch angle/rho onto `angle`/`radius` -> REQ; else advance -> READ, or DONE if last bin.
- REQ: assert `start_draw_a_line` for exactly one cycle, increment `lines_found` -> ACK.
- ACK: wait for `finish_draw_a_line`=0 (highlighter accepted) -> DRAW.
- DRAW: wait for `finish_draw_a_line`=1; then advance counters -> READ, or DONE if bin just drawn was last.
- Counter advance: rho increments; at RHO_BINS-1 rho wraps to 0 and angle increments. Last bin = (ANGLE_RANGE-1, RHO_BINS-1).
- `angle`/`radius` remain stable from REQ through DRAW exit; unchanged otherwise.
- DONE: pulse `done`, drop `busy` -> IDLE.
- `THRESHOLD`=0 dispatches every bin. `lines_found` saturates at 16'hFFFF.

## Timing
- Reset (synchronous): state IDLE; `start_draw_a_line`, `busy`, `done` = 0; `angle`, `radius`, `accum_rd_addr`, `lines_found` = 0.
- Reset mid-scan or mid-draw: next edge returns to IDLE with all outputs at reset values; no further request issued; the highlighter is not waited on.
- `busy` rises the cycle after the accepted `start`.
- Non-peak bin: 2 cycles (READ, CHECK).
- Peak bin: 2 + 1 (REQ) + ACK wait + DRAW wait cycles; `start_draw_a_line` asserts in the cycle after CHECK.
- Full scan with no peaks: 2*ANGLE_RANGE*RHO_BINS cycles from `busy` rise to `done`.
- `finish_draw_a_line` already low in REQ cycle: ACK passes on its first cycle.

## Configuration
- `HOUGH_MAX_LINES_EN` defined: once `lines_found` reaches MAX_LINES, the DRAW exit goes to DONE regardless of remaining bins.
- Not defined: the whole accumulator is always scanned; MAX_LINES is unused.

## Test plan
- ANGLE_RANGE=4, RHO_BINS=8, THRESHOLD=5, all bins 0 -> no `start_draw_a_line`, `done` 64 cycles after `busy`, `lines_found`=0.
- Same, bin (2,3)=5 and (3,7)=9 -> requests angle=2/radius=3 then angle=3/radius=7 (last bin), `lines_found`=2, then `done`.
- Highlighter model holding finish low 10 cycles -> `angle`/`radius` stable throughout, next read only after finish high, one pulse per request.
- `HOUGH_MAX_LINES_EN`, MAX_LINES=2, all bins 9 -> exactly 2 requests (0,0),(0,1), then `done`.
- Reset asserted during DRAW of (1,4) -> next cycle IDLE, all outputs 0; new `start` rescans from (0,0).
- `start` pulsed while busy -> ignored; counters and `lines_found` unaffected.
